issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  Out-of-order issue buffer directly downstream of rename. Captures 89-bit entries from rename
//  (non-load/store ops), tracks per-source readiness against the physical busy state and EXE
//  wakeups, and issues the oldest ready entry, one per cycle, to execute. Raises issue_halt to stall rename.
// PARAMETERS
//  DEPTH   16  number of entries (power of 2, >=4)
//  PREG_W  6   physical register tag width (64 physical registers)
//  ENTRY_W 89  entry width: instr[88:57] pc[56:25] control[24:18] MAPC[17:12] MAPB[11:6] MAPA[5:0]
// PORTS
//  CLK                  in   1        clock; all state updates on posedge
//  RESET                in   1        asynchronous, active-low reset
//  STALL                in   1        global stall: hold all state; no enqueue, no issue
//  FLUSH                in   1        synchronous clear of all entries (mispredict recovery)
//  entry_allocate_issue in   1        rename presents a valid entry this cycle
//  entry_issue          in   ENTRY_W  entry from rename
//  busy                 in   64       physical-register busy vector from rename
//  exe_busyclear_flag   in   1        EXE result broadcast valid
//  exe_busyclear_reg    in   PREG_W   physical tag being produced
//  exe_stall            in   1        execute cannot accept: hold issue outputs
//  issue_valid          out  1        registered: issue_entry valid
//  issue_entry          out  ENTRY_W  registered: issued entry, unmodified
//  issue_halt           out  1        combinational: count >= DEPTH-1
//  iq_count             out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  Reset (RESET low, async): all valid/ready bits 0, count 0, issue_valid 0, issue_entry 0.
//  Storage: collapsing queue; slot 0 oldest; valid slots contiguous from 0 to count-1.
//  Per slot: valid, rdyA, rdyB, entry. Unused sources are supplied by rename with a non-busy tag.
//  Enqueue: when entry_allocate_issue & !STALL & !FLUSH; written to slot count (after collapse).
//   rdyX = !busy[MAPX] | (exe_busyclear_flag & exe_busyclear_reg==MAPX).
//  Wakeup: each cycle (unless STALL/FLUSH) every valid slot with MAPX==exe_busyclear_reg sets rdyX.
//   Wakeup same cycle as enqueue applies to the new entry (see above). Tag 0 treated like any tag.
//  Select: lowest-index slot with valid & rdyA & rdyB, using pre-update state (wakeup at cycle N
//   allows issue decision at N+1; entry appears on issue_entry after posedge N+1).
//  Issue: if a candidate exists and !exe_stall & !STALL: issue_entry<=slot, issue_valid<=1,
//   slot removed, younger slots shift down one. If no candidate and !exe_stall: issue_valid<=0.
//   exe_stall: issue_valid/issue_entry held, no removal.
//  Simultaneous issue+enqueue: count unchanged; new entry lands at count-1 after shift.
//  Full handling: issue_halt = (count >= DEPTH-1), giving one slot of skid for rename's
//   negedge-registered allocate; an enqueue when count==DEPTH is dropped (assertion fires).
//  FLUSH (priority over all but reset): all valid 0, count 0, issue_valid 0 on next posedge;
//   concurrent enqueue and wakeup discarded.
//  STALL: no state change; outputs held; issue_halt still reflects count.
//  Count arithmetic: count_next = count + enq - iss, never wraps; underflow impossible by construction.
// STRUCTURE
//  Shared package (cpu_pkg): ENTRY_W, PREG_W, field offsets (INSTR_MSB..MAPA_LSB),
//   control bit indices (CTL_REGWR=5, CTL_LD=4, CTL_ST=3), iq_entry_t struct.
//  Sub-module iq_slot: one slot's valid/rdy/entry regs + wakeup compare; instantiated DEPTH times;
//   top holds priority select, shift control, counter, output regs.
// TESTING
//  1 Enqueue MAPA=5,MAPB=6 with busy clear -> issue_valid=1 with same entry 1 cycle later, count 0.
//  2 Enqueue A(MAPA=9 busy) then B(ready) -> B issues first; broadcast tag 9 -> A issues next cycle.
//  3 Enqueue with busy[12]=1 and same-cycle exe_busyclear_reg=12 -> entry issues, no lost wakeup.
//  4 Fill 15 entries all busy -> issue_halt=1 at count 15; one more enqueue -> count 16, no drop.
//  5 Full queue, issue+enqueue same cycle -> count stays 16, order preserved oldest-first.
//  6 FLUSH with 8 entries and exe_stall=1; then RESET low mid-issue -> count 0, issue_valid 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, rename-entry field layout and source-ready helper
package cpu_pkg;
   localparam int ENTRY_W   = 89;
   localparam int PREG_W    = 6;
   localparam int NPREG     = 1 << PREG_W;
   localparam int INSTR_MSB = 88;
   localparam int INSTR_LSB = 57;
   localparam int PC_MSB    = 56;
   localparam int PC_LSB    = 25;
   localparam int CTL_MSB   = 24;
   localparam int CTL_LSB   = 18;
   localparam int MAPC_MSB  = 17;
   localparam int MAPC_LSB  = 12;
   localparam int MAPB_MSB  = 11;
   localparam int MAPB_LSB  = 6;
   localparam int MAPA_MSB  = 5;
   localparam int MAPA_LSB  = 0;
   localparam int CTL_REGWR = 5;
   localparam int CTL_LD    = 4;
   localparam int CTL_ST    = 3;

   typedef struct packed {
      logic [31:0]       instr;
      logic [31:0]       pc;
      logic [6:0]        control;
      logic [PREG_W-1:0] mapc;
      logic [PREG_W-1:0] mapb;
      logic [PREG_W-1:0] mapa;
   } iq_entry_t;

   // A source is ready if its producer is done or completes this very cycle
   function automatic logic src_rdy(input logic [NPREG-1:0] bv, input logic [PREG_W-1:0] tag,
                                    input logic wake, input logic [PREG_W-1:0] wake_tag);
      return !bv[tag] || (wake && wake_tag == tag);
   endfunction
endpackage

// File: rtl/iq_slot.sv
// iq_slot: one issue-queue slot; keeps itself, takes its younger neighbour on a
// collapse, or accepts a new entry, applying the EXE tag wakeup on every path
module iq_slot
   import cpu_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              hold,
   input  logic              clear,
   input  logic              wake,
   input  logic [PREG_W-1:0] wake_tag,
   input  logic              shift,
   input  logic              up_valid,
   input  logic              up_rdya,
   input  logic              up_rdyb,
   input  iq_entry_t         up_entry,
   input  logic              load_new,
   input  logic              new_rdya,
   input  logic              new_rdyb,
   input  iq_entry_t         new_entry,
   output logic              valid,
   output logic              rdya,
   output logic              rdyb,
   output iq_entry_t         entry
);
   logic own_a, own_b, up_a, up_b;

   assign own_a = rdya | (valid & wake & (entry.mapa == wake_tag));
   assign own_b = rdyb | (valid & wake & (entry.mapb == wake_tag));
   assign up_a  = up_rdya | (up_valid & wake & (up_entry.mapa == wake_tag));
   assign up_b  = up_rdyb | (up_valid & wake & (up_entry.mapb == wake_tag));

   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         valid <= 1'b0;
         rdya  <= 1'b0;
         rdyb  <= 1'b0;
         entry <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         rdya  <= 1'b0;
         rdyb  <= 1'b0;
      end else if (!hold) begin
         valid <= load_new | (shift ? up_valid : valid);
         rdya  <= load_new ? new_rdya : shift ? up_a : own_a;
         rdyb  <= load_new ? new_rdyb : shift ? up_b : own_b;
         entry <= load_new ? new_entry : shift ? up_entry : entry;
      end
endmodule

// File: rtl/issue_queue.sv
// issue_queue: collapsing out-of-order issue buffer between rename and execute;
// slot 0 is oldest and the oldest fully-ready entry issues each cycle
module issue_queue
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int CNT_W = IDX_W + 1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               STALL,
   input  logic               FLUSH,
   input  logic               entry_allocate_issue,
   input  logic [ENTRY_W-1:0] entry_issue,
   input  logic [NPREG-1:0]   busy,
   input  logic               exe_busyclear_flag,
   input  logic [PREG_W-1:0]  exe_busyclear_reg,
   input  logic               exe_stall,
   output logic               issue_valid,
   output logic [ENTRY_W-1:0] issue_entry,
   output logic               issue_halt,
   output logic [CNT_W-1:0]   iq_count
);
   logic [DEPTH:0]   slot_v, slot_ra, slot_rb;
   iq_entry_t        slot_e [DEPTH+1];
   logic [DEPTH-1:0] cand;
   logic [IDX_W-1:0] sel;
   logic             has_cand, iss, enq_req, enq, new_ra, new_rb;
   logic [CNT_W-1:0] pos;
   iq_entry_t        new_e;

   // Index DEPTH is a permanently empty slot feeding the top of the collapse
   assign slot_v[DEPTH]  = 1'b0;
   assign slot_ra[DEPTH] = 1'b0;
   assign slot_rb[DEPTH] = 1'b0;
   assign slot_e[DEPTH]  = '0;

   assign new_e  = iq_entry_t'(entry_issue);
   assign new_ra = src_rdy(busy, new_e.mapa, exe_busyclear_flag, exe_busyclear_reg);
   assign new_rb = src_rdy(busy, new_e.mapb, exe_busyclear_flag, exe_busyclear_reg);

   assign cand = slot_v[DEPTH-1:0] & slot_ra[DEPTH-1:0] & slot_rb[DEPTH-1:0];

   always_comb begin
      has_cand = 1'b0;
      sel      = '0;
      for (int k = DEPTH - 1; k >= 0; k--)
         if (cand[k]) begin
            has_cand = 1'b1;
            sel      = IDX_W'(k);
         end
   end

   assign iss        = has_cand & ~exe_stall & ~STALL & ~FLUSH;
   assign pos        = iq_count - CNT_W'(iss);
   assign enq_req    = entry_allocate_issue & ~STALL & ~FLUSH;
   assign enq        = enq_req & (pos != CNT_W'(DEPTH));
   assign issue_halt = iq_count >= CNT_W'(DEPTH - 1);

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      iq_slot u_slot (
         .CLK       (CLK),
         .RESET     (RESET),
         .hold      (STALL),
         .clear     (FLUSH),
         .wake      (exe_busyclear_flag),
         .wake_tag  (exe_busyclear_reg),
         .shift     (iss & (IDX_W'(i) >= sel)),
         .up_valid  (slot_v[i+1]),
         .up_rdya   (slot_ra[i+1]),
         .up_rdyb   (slot_rb[i+1]),
         .up_entry  (slot_e[i+1]),
         .load_new  (enq & (pos == CNT_W'(i))),
         .new_rdya  (new_ra),
         .new_rdyb  (new_rb),
         .new_entry (new_e),
         .valid     (slot_v[i]),
         .rdya      (slot_ra[i]),
         .rdyb      (slot_rb[i]),
         .entry     (slot_e[i])
      );
   end

   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         iq_count    <= '0;
         issue_valid <= 1'b0;
         issue_entry <= '0;
      end else if (FLUSH) begin
         iq_count    <= '0;
         issue_valid <= 1'b0;
      end else if (!STALL) begin
         iq_count <= pos + CNT_W'(enq);
         if (!exe_stall) begin
            issue_valid <= has_cand;
            if (has_cand) issue_entry <= slot_e[sel];
         end
      end

   // Rename must honour issue_halt; an enqueue into a full queue is lost
   assert property (@(posedge CLK) disable iff (!RESET) enq_req |-> (pos != CNT_W'(DEPTH)));
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed vector table, corner sequences and randomized run vs a queue model
module tb_issue_queue;
   import cpu_pkg::*;
   localparam int DEPTH = 16;

   logic               CLK = 0, RESET = 0, STALL = 0, FLUSH = 0, alloc = 0, flag = 0, xst = 0;
   logic [ENTRY_W-1:0] ent = '0;
   logic [63:0]        busy = '0;
   logic [5:0]         tag = '0;
   logic               iv, halt;
   logic [ENTRY_W-1:0] ie;
   logic [4:0]         cnt;

   issue_queue #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
      .entry_allocate_issue(alloc), .entry_issue(ent), .busy(busy),
      .exe_busyclear_flag(flag), .exe_busyclear_reg(tag), .exe_stall(xst),
      .issue_valid(iv), .issue_entry(ie), .issue_halt(halt), .iq_count(cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [ENTRY_W-1:0] e;
      bit                 ra, rb;
   } mrec_t;

   typedef struct {
      bit          alloc;
      int          id, ma, mb;
      logic [63:0] busy;
      bit          flag;
      int          tag;
      bit          xst, stl, fl;
      bit          ev;
      int          eid, ecnt;
   } vec_t;

   mrec_t              q[$];
   logic               m_iv = 0;
   logic [ENTRY_W-1:0] m_ie = '0;
   int                 n_tests = 0, n_fail = 0;
   vec_t               tbl[$];

   function automatic logic [ENTRY_W-1:0] mk(int id, int ma, int mb);
      return {32'(id), 32'(id * 4), 7'b0100000, 6'(id), 6'(mb), 6'(ma)};
   endfunction

   function automatic vec_t v(bit a, int id, int ma, int mb, logic [63:0] bz, bit f, int t,
                              bit x, bit s, bit fl, bit ev, int eid, int ecnt);
      vec_t r;
      r = '{a, id, ma, mb, bz, f, t, x, s, fl, ev, eid, ecnt};
      return r;
   endfunction

   task automatic chk(string nm, logic [ENTRY_W-1:0] act, logic [ENTRY_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(bit a, logic [ENTRY_W-1:0] e, logic [63:0] bz, bit f, int t, bit x, bit s, bit fl);
      alloc = a; ent = e; busy = bz; flag = f; tag = 6'(t); xst = x; STALL = s; FLUSH = fl;
   endtask

   // Queue-level reference: oldest-first list, issue removes, wakeup marks, enqueue appends
   task automatic model_step();
      int k;
      mrec_t r;
      if (FLUSH) begin
         q.delete();
         m_iv = 0;
      end else if (!STALL) begin
         k = -1;
         for (int i = 0; i < q.size(); i++) if (k < 0 && q[i].ra && q[i].rb) k = i;
         if (!xst) begin
            m_iv = (k >= 0);
            if (k >= 0) begin
               m_ie = q[k].e;
               q.delete(k);
            end
         end
         if (flag)
            for (int i = 0; i < q.size(); i++) begin
               if (q[i].e[5:0] == tag) q[i].ra = 1;
               if (q[i].e[11:6] == tag) q[i].rb = 1;
            end
         if (alloc && q.size() < DEPTH) begin
            r.e  = ent;
            r.ra = !busy[ent[5:0]] || (flag && tag == ent[5:0]);
            r.rb = !busy[ent[11:6]] || (flag && tag == ent[11:6]);
            q.push_back(r);
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_step();
      #1;
      chk("count", ENTRY_W'(cnt), ENTRY_W'(q.size()));
      chk("valid", ENTRY_W'(iv), ENTRY_W'(m_iv));
      if (m_iv) chk("entry", ie, m_ie);
      chk("halt", ENTRY_W'(halt), ENTRY_W'(q.size() >= DEPTH - 1));
   endtask

   initial begin
      #12;
      chk("reset_count", ENTRY_W'(cnt), '0);
      chk("reset_valid", ENTRY_W'(iv), '0);
      chk("reset_entry", ie, '0);
      chk("reset_halt", ENTRY_W'(halt), '0);
      @(negedge CLK);
      RESET = 1;

      // alloc id ma mb busy flag tag xst stl fl | ev eid ecnt
      tbl.push_back(v(1, 1, 5, 6, 64'd0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(v(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 2, 9, 1, 64'd1 << 9, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 3, 1, 2, 64'd1 << 9, 0, 0, 0, 0, 0, 0, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 64'd1 << 9, 0, 0, 0, 0, 0, 1, 3, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'd1 << 9, 1, 9, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1, 2, 0));
      tbl.push_back(v(1, 4, 12, 0, 64'd1 << 12, 1, 12, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'd1 << 12, 0, 0, 0, 0, 0, 1, 4, 0));
      tbl.push_back(v(1, 5, 0, 7, 64'h81, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'h81, 1, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'h81, 1, 7, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'h81, 0, 0, 0, 0, 0, 1, 5, 0));
      tbl.push_back(v(1, 6, 1, 1, 64'd0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 7, 1, 1, 64'd0, 0, 0, 0, 0, 0, 1, 6, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'd0, 0, 0, 1, 0, 0, 1, 6, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1, 7, 0));
      tbl.push_back(v(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 8, 1, 1, 64'd0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 9, 1, 1, 64'd0, 0, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 1, 8, 0));
      tbl.push_back(v(1, 10, 1, 1, 64'd0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 11, 1, 1, 64'd0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (tbl[n]) begin
         drive(tbl[n].alloc, mk(tbl[n].id, tbl[n].ma, tbl[n].mb), tbl[n].busy, tbl[n].flag,
               tbl[n].tag, tbl[n].xst, tbl[n].stl, tbl[n].fl);
         step();
         chk($sformatf("tbl%0d_valid", n), ENTRY_W'(iv), ENTRY_W'(tbl[n].ev));
         if (tbl[n].ev) chk($sformatf("tbl%0d_id", n), ENTRY_W'(ie[88:57]), ENTRY_W'(tbl[n].eid));
         chk($sformatf("tbl%0d_count", n), ENTRY_W'(cnt), ENTRY_W'(tbl[n].ecnt));
      end

      // fill to the halt threshold, then use the skid slot
      for (int i = 0; i < 15; i++) begin
         drive(1, mk(100 + i, 20, 20), 64'd1 << 20, 0, 0, 0, 0, 0);
         step();
         if (i == 13) chk("halt_at_14", ENTRY_W'(halt), '0);
      end
      chk("fill_count", ENTRY_W'(cnt), ENTRY_W'(15));
      chk("halt_at_15", ENTRY_W'(halt), ENTRY_W'(1));
      drive(1, mk(115, 20, 20), 64'd1 << 20, 0, 0, 0, 0, 0);
      step();
      chk("skid_count", ENTRY_W'(cnt), ENTRY_W'(16));

      // full queue: wake all, then issue and enqueue together, drain in order
      drive(0, '0, 64'd1 << 20, 1, 20, 0, 0, 0);
      step();
      drive(1, mk(200, 1, 1), 64'd0, 0, 0, 0, 0, 0);
      step();
      chk("full_swap_count", ENTRY_W'(cnt), ENTRY_W'(16));
      chk("full_swap_id", ENTRY_W'(ie[88:57]), ENTRY_W'(100));
      drive(0, '0, 64'd0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 15; k++) begin
         step();
         chk($sformatf("drain_id%0d", k), ENTRY_W'(ie[88:57]), ENTRY_W'(100 + k));
      end
      step();
      chk("drain_last_id", ENTRY_W'(ie[88:57]), ENTRY_W'(200));
      chk("drain_count", ENTRY_W'(cnt), '0);

      // flush eight entries under exe_stall, with a concurrent enqueue and wakeup
      drive(1, mk(300, 1, 1), 64'd0, 0, 0, 0, 0, 0);
      step();
      drive(1, mk(301, 21, 21), 64'd1 << 21, 0, 0, 0, 0, 0);
      step();
      for (int i = 2; i < 9; i++) begin
         drive(1, mk(300 + i, 21, 21), 64'd1 << 21, 0, 0, 1, 0, 0);
         step();
      end
      chk("preflush_count", ENTRY_W'(cnt), ENTRY_W'(8));
      chk("preflush_valid", ENTRY_W'(iv), ENTRY_W'(1));
      drive(1, mk(399, 1, 1), 64'd0, 1, 21, 1, 0, 1);
      step();
      chk("flush_count", ENTRY_W'(cnt), '0);
      chk("flush_valid", ENTRY_W'(iv), '0);
      drive(0, '0, 64'd0, 0, 0, 0, 0, 0);
      step();
      drive(1, mk(400, 1, 1), 64'd0, 0, 0, 0, 0, 0);
      step();
      drive(1, mk(401, 1, 1), 64'd0, 0, 0, 0, 0, 0);
      step();
      chk("preRESET_valid", ENTRY_W'(iv), ENTRY_W'(1));
      #1 RESET = 0;
      #1;
      chk("async_count", ENTRY_W'(cnt), '0);
      chk("async_valid", ENTRY_W'(iv), '0);
      chk("async_entry", ie, '0);
      q.delete();
      m_iv = 0;
      m_ie = '0;
      drive(0, '0, 64'd0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      RESET = 1;

      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 99) < 60) && (q.size() < DEPTH),
               mk(1000 + n, $urandom_range(0, 7), $urandom_range(0, 7)),
               64'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
               $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
